// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog timeout controller and the WDT wrapper:
// FSM state encoding, default sizing and the WDT register map.
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        IRQ_PEND   = 2'd1,
        RST_ASSERT = 2'd2,
        HOLDOFF    = 2'd3
    } wdt_to_state_e;

    localparam int WDT_GRACE_DEF     = 1024;
    localparam int WDT_RST_PULSE_DEF = 16;
    localparam int WDT_CNT_W_DEF     = 8;

    localparam logic [31:0] WDT_CTRL_ADDR   = 32'h1001_0100;
    localparam logic [31:0] WDT_LOAD_ADDR   = 32'h1001_0200;
    localparam logic [31:0] WDT_STATUS_ADDR = 32'h1001_0300;

    // Counter width able to hold the value n itself, so terminal values never wrap.
    function automatic int wdt_cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/wdt_timeout_ctrl_if.sv
// Control/status bundle between the timeout controller, the WDT wrapper,
// the CPU interrupt input and the system reset tree.
interface wdt_timeout_ctrl_if
    import wdt_pkg::*;
#(
    parameter int CNT_W = WDT_CNT_W_DEF
) ();

    logic             WTO;
    logic             irq_en;
    logic             rst_en;
    logic             irq_clr;
    logic             cnt_clr;
    logic             WDT_IRQ;
    logic             SYS_RSTn;
    logic [CNT_W-1:0] TO_CNT;
    logic [1:0]       STATE;

    modport master (
        output WTO, irq_en, rst_en, irq_clr, cnt_clr,
        input  WDT_IRQ, SYS_RSTn, TO_CNT, STATE
    );

    modport slave (
        input  WTO, irq_en, rst_en, irq_clr, cnt_clr,
        output WDT_IRQ, SYS_RSTn, TO_CNT, STATE
    );

endinterface

// File: rtl/wdt_edge_det.sv
// Registers a level and flags its rising edge combinationally, so a level
// held high yields exactly one single-cycle pulse.
module wdt_edge_det (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic din,
    output logic din_q,
    output logic rise
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) din_q <= 1'b0;
        else          din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/wdt_timeout_ctrl.sv
// Turns a watchdog timeout edge into an interrupt, escalates to a fixed-width
// system reset pulse if unacknowledged, and counts timeout events.
module wdt_timeout_ctrl
    import wdt_pkg::*;
#(
    parameter int GRACE_CYCLES = WDT_GRACE_DEF,
    parameter int RST_PULSE    = WDT_RST_PULSE_DEF,
    parameter int CNT_W        = WDT_CNT_W_DEF
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    wdt_timeout_ctrl_if.slave  bus
);

    localparam int GW = wdt_cnt_width(GRACE_CYCLES);
    localparam int PW = wdt_cnt_width(RST_PULSE);

    localparam logic [GW-1:0]    GRACE_LAST = GW'(GRACE_CYCLES - 1);
    localparam logic [PW-1:0]    PULSE_LAST = PW'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    wdt_to_state_e    state, state_nxt;
    logic [GW-1:0]    grace_cnt, grace_nxt;
    logic [PW-1:0]    pulse_cnt, pulse_nxt;
    logic [CNT_W-1:0] to_cnt;
    logic             irq_q;
    logic             rstn_q;
    logic             wto_q;
    logic             wto_evt;

    wdt_edge_det u_edge_det (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .din     (bus.WTO),
        .din_q   (wto_q),
        .rise    (wto_evt)
    );

    // SYS_RSTn must not feed back into ARESETn, so TO_CNT outlives the pulse.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= IDLE;
            grace_cnt <= '0;
            pulse_cnt <= '0;
            irq_q     <= 1'b0;
            rstn_q    <= 1'b1;
            to_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            grace_cnt <= grace_nxt;
            pulse_cnt <= pulse_nxt;
            irq_q     <= (state == IRQ_PEND);
            rstn_q    <= (state != RST_ASSERT);
            if (bus.cnt_clr)
                to_cnt <= '0;
            else if (wto_evt && (to_cnt != CNT_MAX))
                to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    // NOTE: every output of this block is defaulted first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        grace_nxt = grace_cnt;
        pulse_nxt = pulse_cnt;
        unique case (state)
            IDLE: begin
                if (wto_evt) begin
                    if (bus.irq_en) begin
                        state_nxt = IRQ_PEND;
                        grace_nxt = '0;
                    end else if (bus.rst_en) begin
                        state_nxt = RST_ASSERT;
                        pulse_nxt = '0;
                    end
                end
            end
            IRQ_PEND: begin
                if (bus.irq_clr) begin
                    state_nxt = IDLE;
                end else if (grace_cnt == GRACE_LAST) begin
                    // Without rst_en the counter parks at its terminal value.
                    if (bus.rst_en) begin
                        state_nxt = RST_ASSERT;
                        pulse_nxt = '0;
                    end
                end else begin
                    grace_nxt = grace_cnt + GW'(1);
                end
            end
            RST_ASSERT: begin
                if (pulse_cnt == PULSE_LAST)
                    state_nxt = HOLDOFF;
                else
                    pulse_nxt = pulse_cnt + PW'(1);
            end
            HOLDOFF: begin
                // A stale high WTO must drop before the next edge can re-arm us.
                if (!wto_q)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.WDT_IRQ  = irq_q;
    assign bus.SYS_RSTn = rstn_q;
    assign bus.TO_CNT   = to_cnt;
    assign bus.STATE    = state;

endmodule

// File: tb/tb_wdt_timeout_ctrl.sv
// Self-checking bench for wdt_timeout_ctrl: directed scenarios plus random
// stimulus compared every cycle against a deadline-based reference model.
module tb_wdt_timeout_ctrl;
    import wdt_pkg::*;

    localparam int GRACE = 8;
    localparam int PULSE = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;

    wdt_timeout_ctrl_if #(.CNT_W(CW)) bus ();

    wdt_timeout_ctrl #(
        .GRACE_CYCLES (GRACE),
        .RST_PULSE    (PULSE),
        .CNT_W        (CW)
    ) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: phases with absolute deadlines instead of counters.
    int m_phase    = 0;   // 0 idle, 1 irq pending, 2 reset pulse, 3 holdoff
    int m_deadline = 0;   // cycle at which the current timed phase ends
    int m_cnt      = 0;
    bit m_wto_prev = 1'b0;
    bit m_irq      = 1'b0;
    bit m_rstn     = 1'b1;

    task automatic model_step(input bit wto, input bit irq_en, input bit rst_en,
                              input bit irq_clr, input bit cnt_clr, input bit rstn);
        bit ev;
        cyc++;
        if (!rstn) begin
            m_phase = 0; m_cnt = 0; m_wto_prev = 1'b0; m_irq = 1'b0; m_rstn = 1'b1;
            return;
        end
        ev     = wto && !m_wto_prev;
        m_irq  = (m_phase == 1);
        m_rstn = (m_phase != 2);
        if (cnt_clr)  m_cnt = 0;
        else if (ev)  m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        case (m_phase)
            0: begin
                if (ev && irq_en)      begin m_phase = 1; m_deadline = cyc + GRACE; end
                else if (ev && rst_en) begin m_phase = 2; m_deadline = cyc + PULSE; end
            end
            1: begin
                if (irq_clr) m_phase = 0;
                else if (cyc >= m_deadline && rst_en) begin
                    m_phase = 2; m_deadline = cyc + PULSE;
                end
            end
            2: if (cyc >= m_deadline) m_phase = 3;
            default: if (!m_wto_prev) m_phase = 0;
        endcase
        m_wto_prev = wto;
    endtask

    bit c_wto = 0, c_irq_en = 0, c_rst_en = 0;

    task automatic tick(input bit irq_clr, input bit cnt_clr, input bit rstn);
        bus.WTO     = c_wto;
        bus.irq_en  = c_irq_en;
        bus.rst_en  = c_rst_en;
        bus.irq_clr = irq_clr;
        bus.cnt_clr = cnt_clr;
        ARESETn     = rstn;
        model_step(c_wto, c_irq_en, c_rst_en, irq_clr, cnt_clr, rstn);
        @(negedge ACLK);
        check("WDT_IRQ",  {31'b0, bus.WDT_IRQ},  {31'b0, m_irq});
        check("SYS_RSTn", {31'b0, bus.SYS_RSTn}, {31'b0, m_rstn});
        check("TO_CNT",   32'(bus.TO_CNT),       m_cnt);
        check("STATE",    {30'b0, bus.STATE},    m_phase);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.WTO = 1'b0; bus.irq_en = 1'b0; bus.rst_en = 1'b0;
        bus.irq_clr = 1'b0; bus.cnt_clr = 1'b0;
        @(negedge ACLK);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // Acknowledged interrupt
        c_irq_en = 1; c_rst_en = 1;
        run(8);
        c_wto = 1; run(4);
        tick(1'b1, 1'b0, 1'b1);
        run(3);
        check("ack_cnt", 32'(bus.TO_CNT), 1);
        c_wto = 0; run(2);

        // Unacknowledged: escalation, then holdoff on stale WTO
        c_wto = 1; run(25);
        check("holdoff", {30'b0, bus.STATE}, 3);
        c_wto = 0; run(3);

        // Direct reset path
        c_irq_en = 0; c_rst_en = 1;
        c_wto = 1; run(10);
        c_wto = 0; run(3);

        // Interrupt held without escalation permission
        c_irq_en = 1; c_rst_en = 0;
        c_wto = 1; run(110);
        check("irq_held", {31'b0, bus.WDT_IRQ}, 1);
        tick(1'b1, 1'b0, 1'b1);
        c_wto = 0; run(3);

        // irq_clr exactly on the grace-expiry cycle wins
        c_irq_en = 1; c_rst_en = 1;
        c_wto = 1; tick(1'b0, 1'b0, 1'b1);
        run(GRACE - 1);
        tick(1'b1, 1'b0, 1'b1);
        run(6);
        check("clr_at_expiry", {30'b0, bus.STATE}, 0);
        c_wto = 0; run(2);

        // Counter saturation, then clear beating a coincident event
        c_irq_en = 0; c_rst_en = 0;
        for (int i = 0; i < 300; i++) begin
            c_wto = 1; run(1);
            c_wto = 0; run(1);
        end
        check("saturate", 32'(bus.TO_CNT), CMAX);
        c_wto = 1; tick(1'b0, 1'b1, 1'b1);
        check("clr_wins", 32'(bus.TO_CNT), 0);
        c_wto = 0; run(2);

        // Reset in the middle of the reset pulse
        c_rst_en = 1;
        c_wto = 1; run(3);
        c_wto = 0; tick(1'b0, 1'b0, 1'b0);
        run(8);

        // Random stimulus
        for (int i = 0; i < 4000; i++) begin
            bit clr_i, cclr_i, rstn_i;
            if ($urandom_range(7) == 0)  c_wto    = ~c_wto;
            if ($urandom_range(49) == 0) c_irq_en = ~c_irq_en;
            if ($urandom_range(49) == 0) c_rst_en = ~c_rst_en;
            clr_i  = ($urandom_range(11) == 0);
            cclr_i = ($urandom_range(63) == 0);
            rstn_i = ($urandom_range(499) != 0);
            tick(clr_i, cclr_i, rstn_i);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wdt_timeout_ctrl.md
Name: wdt_timeout_ctrl

Overview:
Downstream consumer of the watchdog's WTO output. It turns a WTO rising edge into a CPU interrupt (WDT_IRQ). If software does not acknowledge the interrupt within a grace window, it escalates to a fixed-width system reset pulse (SYS_RSTn). It also keeps a saturating count of timeout events for post-reset diagnosis. It sits between the WDT wrapper and the CPU interrupt input / system reset tree.

Parameters:
GRACE_CYCLES, 1024, ACLK cycles allowed between IRQ assertion and reset escalation (>=1)
RST_PULSE, 16, ACLK cycles SYS_RSTn is held low (>=1)
CNT_W, 8, width of the saturating timeout event counter

Ports:
ACLK  input  1  clock
ARESETn  input  1  reset, synchronous, active-low
WTO  input  1  watchdog timeout level from WDT wrapper (ACLK domain)
irq_en  input  1  level; 1 = route timeout to WDT_IRQ first
rst_en  input  1  level; 1 = escalation to SYS_RSTn permitted
irq_clr  input  1  single-cycle acknowledge from software/ISR
cnt_clr  input  1  single-cycle clear of TO_CNT
WDT_IRQ  output  1  interrupt request, active-high level
SYS_RSTn  output  1  system reset request, active-low
TO_CNT  output  CNT_W  saturating count of WTO rising edges
STATE  output  2  current FSM state, for debug and status reads

Behaviour:
- Reset (ARESETn=0 at posedge ACLK): state IDLE; WDT_IRQ=0; SYS_RSTn=1; TO_CNT=0; grace and pulse counters 0; wto_q=0.
- SYS_RSTn must not be routed back to this block's ARESETn. TO_CNT survives the pulse it generates.
- Edge detect: wto_q registers WTO. The event is WTO & ~wto_q, evaluated combinationally. A WTO held high produces exactly one event.
- States (enum in package): IDLE=0, IRQ_PEND=1, RST_ASSERT=2, HOLDOFF=3. Outputs are Moore-decoded and registered: WDT_IRQ=(state==IRQ_PEND); SYS_RSTn=~(state==RST_ASSERT).
- IDLE:
  - on event with irq_en=1 -> IRQ_PEND, grace counter cleared.
  - on event with irq_en=0, rst_en=1 -> RST_ASSERT, pulse counter cleared.
  - on event with both 0 -> stay IDLE; the event is only counted.
- IRQ_PEND:
  - grace counter increments each cycle.
  - irq_clr=1 -> IDLE. irq_clr wins over grace expiry in the same cycle.
  - grace counter == GRACE_CYCLES-1 with no irq_clr: rst_en=1 -> RST_ASSERT; rst_en=0 -> stay in IRQ_PEND, counter holds at its terminal value.
- RST_ASSERT: pulse counter increments. When it reaches RST_PULSE-1 -> HOLDOFF. SYS_RSTn is therefore low for exactly RST_PULSE cycles.
- HOLDOFF: wait while wto_q=1; when wto_q=0 -> IDLE. This prevents re-trigger from a stale WTO level.
- Latency: WTO seen high at posedge k (previously low) -> WDT_IRQ or SYS_RSTn change visible after posedge k+1.
- Events while not in IDLE: they do not change state, but are counted.
- TO_CNT:
  - +1 per event, saturating at 2^CNT_W-1.
  - cnt_clr forces 0; cnt_clr and an event in the same cycle -> 0 (clear wins).
- irq_clr outside IRQ_PEND: ignored.
- irq_en / rst_en changing mid-state: sampled only at the decision points above, never cached.
- Counter widths: $clog2(GRACE_CYCLES+1) and $clog2(RST_PULSE+1). No wrap is permitted; counters are cleared on state entry.
- Reset mid-operation: any state returns to IDLE next cycle, WDT_IRQ=0, SYS_RSTn=1 immediately registered.

Decomposition:
- Package wdt_pkg: state enum wdt_to_state_e (2-bit), default constants WDT_GRACE_DEF=1024, WDT_RST_PULSE_DEF=16, WDT_CNT_W_DEF=8, the WDT register addresses (10010100/200/300) shared with the wrapper.
- One natural sub-module: wdt_edge_det (register plus rising-edge pulse). FSM and counters stay inline.

Test Plan:
Bench parameters GRACE_CYCLES=8, RST_PULSE=4 throughout.
1. irq_en=1, rst_en=1; WTO 0->1 at cycle 10 -> WDT_IRQ=1 from cycle 12; irq_clr at cycle 15 -> WDT_IRQ=0 at 16; SYS_RSTn stays 1; TO_CNT=1.
2. Same setup, no irq_clr -> WDT_IRQ high 8 cycles, then SYS_RSTn=0 for exactly 4 cycles, WDT_IRQ=0 during the pulse; WTO kept high -> HOLDOFF until WTO=0, then IDLE.
3. irq_en=0, rst_en=1; WTO rise -> SYS_RSTn low 2 cycles later for 4 cycles, WDT_IRQ never asserts.
4. irq_en=1, rst_en=0, no ack -> WDT_IRQ stays high for 100+ cycles, SYS_RSTn stays 1; irq_clr then clears it.
5. irq_clr on the exact grace-expiry cycle -> IDLE, no reset pulse. Apply 300 WTO pulses -> TO_CNT saturates at 255. cnt_clr coincident with an event -> TO_CNT=0.
6. ARESETn low for 1 cycle during RST_ASSERT -> next cycle SYS_RSTn=1, WDT_IRQ=0, TO_CNT=0, STATE=0.
